sfu_seq: RTL

Sequencer for one accumulation/ReLU special-function lane. It drains partial sums from the output FIFO in bursts of NTAP consecutive reads, one burst per output pixel (NTAP=9 for 3x3 convolution). It drives the lane's accumulate-enable, then writes each rectified result to output memory at an incrementing pixel address. It sits between the output FIFO, the SFU lane and the output SRAM write port, and is started once per output tile by the top-level controller.

---
 rtl/sfu_seq.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/sfu_seq.sv
// ---------------------------------------------------------------------------
// sfu_seq -- sequencer for one accumulate/ReLU special-function lane.
//
// Each output pixel is produced by draining NTAP partial sums from the output
// FIFO in one unbroken burst of reads. During the burst the SFU accumulate
// enable is held high. One idle (DRAIN) cycle follows, in which the SFU latches
// ReLU(sum) and clears itself. The result is then written to output memory at
// the pixel's address. The top-level controller starts the sequencer once for
// each tile of NPIX pixels.
//
// Optional feature macro: SFU_SEQ_PERF_EN
//   defined   -> stall_cycles counts the WAIT cycles spent starved of data.
//                It saturates at 16'hFFFF and clears on reset and on start.
//   undefined -> stall_cycles is tied to zero and no counter is built.
//
// Ports
//   clk            in   clock
//   reset          in   synchronous, active-high reset
//   start          in   begin a tile (sampled only while idle)
//   ofifo_cnt      in   output FIFO occupancy
//   ofifo_valid    in   FIFO head valid
//   ofifo_rd       out  FIFO pop (head data feeds the SFU psum input directly)
//   sfu_acc        out  SFU accumulate enable (low = latch ReLU result, clear)
//   sfp_out        in   SFU result
//   out_wr         out  output memory write strobe
//   out_addr       out  output memory address (pixel index)
//   out_data       out  output memory write data (sfp_out passed through)
//   busy           out  high in every state except IDLE
//   done           out  one-cycle pulse at the end of a tile
//   err_underflow  out  sticky flag: FIFO head was invalid during a burst
//   stall_cycles   out  starved WAIT cycles (zero unless SFU_SEQ_PERF_EN)
//   dbg_state_o    out  current FSM state encoding, for observation
//
// Handshake semantics: the FIFO side is not a valid/ready pair. A burst starts
// only when ofifo_cnt >= NTAP. From then on ofifo_rd is asserted for NTAP
// consecutive cycles without looking at ofifo_valid, because the SFU clears
// its accumulator on any cycle with sfu_acc low and so a burst cannot pause.
// If ofifo_valid is low during one of these reads, err_underflow records it
// and the burst still runs to completion. out_wr is a one-cycle strobe that
// has no back-pressure; out_addr and out_data are valid only while it is high.
// ---------------------------------------------------------------------------
module sfu_seq #(
    parameter int NTAP    = 9,
    parameter int NPIX    = 16,
    parameter int PSUM_BW = 16,
    parameter int CNT_W   = 5,
    parameter int ADDR_W  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [CNT_W-1:0]   ofifo_cnt,
    input  logic               ofifo_valid,
    output logic               ofifo_rd,
    output logic               sfu_acc,
    input  logic [PSUM_BW-1:0] sfp_out,
    output logic               out_wr,
    output logic [ADDR_W-1:0]  out_addr,
    output logic [PSUM_BW-1:0] out_data,
    output logic               busy,
    output logic               done,
    output logic               err_underflow,
    output logic [15:0]        stall_cycles,
    output logic [2:0]         dbg_state_o
);

    localparam int TAP_W = (NTAP > 1) ? $clog2(NTAP) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_ACC   = 3'd2,
        S_DRAIN = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [TAP_W-1:0]    tap_cnt_q, tap_cnt_d;
    logic [ADDR_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic                err_q, err_d;

    logic                cnt_ok;
    logic                tap_last;
    logic                pix_last;

    // A burst may begin only if the whole burst is already buffered.
    // The occupancy is zero-extended before the compare, so a narrow
    // occupancy field never truncates NTAP.
    assign cnt_ok   = (32'(ofifo_cnt) >= 32'(NTAP));
    assign tap_last = (tap_cnt_q == TAP_W'(NTAP - 1));
    assign pix_last = (pix_cnt_q == ADDR_W'(NPIX - 1));

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            tap_cnt_q <= '0;
            pix_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tap_cnt_q <= tap_cnt_d;
            pix_cnt_q <= pix_cnt_d;
            err_q     <= err_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and strobes. The strobes depend only on state_q, so there is
    // no combinational path from any input to ofifo_rd, sfu_acc, out_wr or
    // done.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        tap_cnt_d = tap_cnt_q;
        pix_cnt_d = pix_cnt_q;
        err_d     = err_q;

        ofifo_rd  = 1'b0;
        sfu_acc   = 1'b0;
        out_wr    = 1'b0;
        done      = 1'b0;
        busy      = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_WAIT;
                    pix_cnt_d = '0;
                    tap_cnt_d = '0;
                end
            end

            S_WAIT: begin
                if (cnt_ok) begin
                    state_d = S_ACC;
                end
            end

            S_ACC: begin
                ofifo_rd = 1'b1;
                sfu_acc  = 1'b1;
                // The read still issues on an empty head; only the flag records it.
                if (!ofifo_valid) begin
                    err_d = 1'b1;
                end
                if (tap_last) begin
                    tap_cnt_d = '0;
                    state_d   = S_DRAIN;
                end else begin
                    tap_cnt_d = tap_cnt_q + TAP_W'(1);
                end
            end

            S_DRAIN: begin
                // sfu_acc is low here, so the SFU latches ReLU(sum) and clears.
                state_d = S_WRITE;
            end

            S_WRITE: begin
                out_wr = 1'b1;
                if (pix_last) begin
                    state_d = S_DONE;
                end else begin
                    pix_cnt_d = pix_cnt_q + ADDR_W'(1);
                    // Go straight to the next burst when the data is already
                    // buffered, which gives one pixel every NTAP+2 cycles.
                    state_d   = cnt_ok ? S_ACC : S_WAIT;
                end
            end

            S_DONE: begin
                done      = 1'b1;
                pix_cnt_d = '0;
                state_d   = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign out_addr      = pix_cnt_q;
    assign out_data      = sfp_out;
    assign err_underflow = err_q;
    assign dbg_state_o   = state_q;

    // -----------------------------------------------------------------------
    // Optional starvation counter
    // -----------------------------------------------------------------------
`ifdef SFU_SEQ_PERF_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == S_IDLE && start) begin
            stall_d = '0;
        end else if (state_q == S_WAIT && !cnt_ok && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 16'd0;
`endif

endmodule
